// File: rtl/cmd_parser.sv
// cmd_parser: frames SUMP short (1-byte) and long (opcode + 4 data bytes) commands from a byte stream,
// discarding partial long commands after an inter-byte timeout.
module cmd_parser #(
  parameter int TIMEOUT = 100000,
  parameter int CW      = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [7:0]  cmd_code,
  output logic [31:0] cmd_data,
  output logic        cmd_valid,
  output logic        busy,
  output logic        timeout_err
);
  typedef enum logic {IDLE, DATA} state_t;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t        state;
  logic [7:0]    opcode;
  logic [31:0]   shadow;
  logic [1:0]    cnt;
  logic [CW-1:0] tmr;
  logic          expire;
  assign expire = (TIMEOUT > 0) && (state == DATA) && !rx_valid && (tmr == TLIM);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      opcode      <= '0;
      shadow      <= '0;
      cnt         <= '0;
      tmr         <= '0;
      cmd_code    <= '0;
      cmd_data    <= '0;
      cmd_valid   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      timeout_err <= 1'b0;
      if (state == IDLE) begin
        tmr <= '0;
        if (rx_valid && !rx_data[7]) begin
          cmd_code  <= rx_data;
          cmd_data  <= '0;
          cmd_valid <= 1'b1;
        end else if (rx_valid) begin
          opcode <= rx_data;
          shadow <= '0;
          cnt    <= '0;
          state  <= DATA;
          busy   <= 1'b1;
        end
      end else if (rx_valid) begin
        tmr                  <= '0;
        cnt                  <= cnt + 2'd1;
        shadow[{cnt, 3'b000} +: 8] <= rx_data;
        if (cnt == 2'd3) begin
          cmd_code  <= opcode;
          cmd_data  <= {rx_data, shadow[23:0]};
          cmd_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      end else if (expire) begin
        timeout_err <= 1'b1;
        busy        <= 1'b0;
        state       <= IDLE;
        tmr         <= '0;
      end else if (TIMEOUT > 0 && tmr != '1) begin
        tmr <= tmr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cmd_parser.sv
// tb_cmd_parser: directed and random byte streams checked against a queue-based command framing model.
module tb_cmd_parser;
  localparam int TO = 10;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [7:0]  cmd_code;
  logic [31:0] cmd_data;
  logic        cmd_valid, busy, timeout_err;
  cmd_parser #(.TIMEOUT(TO), .CW(5)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .cmd_code(cmd_code), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .busy(busy), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0]  pend[$];
  int          gap;
  logic [7:0]  e_code;
  logic [31:0] e_data;
  logic        e_valid, e_busy, e_terr;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("cmd_valid", 32'(cmd_valid), 32'(e_valid));
    chk("timeout_err", 32'(timeout_err), 32'(e_terr));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("cmd_code", 32'(cmd_code), 32'(e_code));
    chk("cmd_data", cmd_data, e_data);
  endtask
  task automatic model_reset();
    pend.delete();
    gap = 0;
    e_code = '0; e_data = '0; e_valid = 0; e_busy = 0; e_terr = 0;
  endtask
  // One clock of framing behaviour: a command is either one byte with bit7 clear or five bytes
  task automatic model(input logic v, input logic [7:0] d);
    e_valid = 0;
    e_terr  = 0;
    if (pend.size() == 0) begin
      if (v && !d[7]) begin
        e_code = d; e_data = '0; e_valid = 1;
      end else if (v) begin
        pend.push_back(d); gap = 0;
      end
    end else if (v) begin
      pend.push_back(d);
      gap = 0;
      if (pend.size() == 5) begin
        e_code  = pend[0];
        e_data  = {pend[4], pend[3], pend[2], pend[1]};
        e_valid = 1;
        pend.delete();
      end
    end else begin
      gap++;
      if (gap == TO) begin
        e_terr = 1;
        pend.delete();
      end
    end
    e_busy = pend.size() != 0;
  endtask
  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model(v, d);
    #1 check_all();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask
  initial begin
    model_reset();
    #12 check_all();
    @(negedge clk) rst = 1'b0;
    idle(1);
    step(1'b1, 8'h01); idle(3);
    step(1'b1, 8'hC0); step(1'b1, 8'h11); step(1'b1, 8'h22); step(1'b1, 8'h33); step(1'b1, 8'h44); idle(2);
    step(1'b1, 8'h82); step(1'b1, 8'hA1); step(1'b1, 8'hB2); step(1'b1, 8'hC3); step(1'b1, 8'hD4);
    step(1'b1, 8'h02); idle(2);
    step(1'b1, 8'h81); step(1'b1, 8'hAA); idle(12);
    step(1'b1, 8'h00); idle(2);
    step(1'b1, 8'h81);
    for (int i = 0; i < 4; i++) begin
      idle(TO - 1);
      step(1'b1, 8'($urandom));
    end
    idle(2);
    step(1'b1, 8'hC0); step(1'b1, 8'h5A); step(1'b1, 8'hA5);
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk) rst = 1'b0;
    step(1'b1, 8'h11); idle(2);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(0, TO + 2));
      else step(1'b1, 8'($urandom));
    end
    idle(TO + 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
